// File: rtl/decode_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : decode_scoreboard_pkg
//  Brief   : Shared sizing constants for the register-busy scoreboard, reused
//            by issue and hazard logic.
//  Revision: 1.0 - initial release
// ============================================================================
package decode_scoreboard_pkg;

    // Default register-number width and the entry count it implies
    localparam int c_addr_w = 5;
    localparam int c_n      = 2 ** c_addr_w;

    // Default outstanding-write counter width and its saturation value
    localparam int c_cnt_w   = 2;
    localparam int c_cnt_sat = (2 ** c_cnt_w) - 1;

    // Saturation value of a counter of arbitrary width
    function automatic int cnt_sat(input int cnt_w);
        return (2 ** cnt_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard_onehot_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_decoder
//  Brief   : Binary register number to one-hot vector, gated by an enable.
//  Revision: 1.0 - initial release
// ============================================================================
module onehot_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    // Single hot bit at addr when enabled, all zero otherwise
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : decode_scoreboard
//  Brief   : Per-register outstanding-write counters with issue back-pressure,
//            multi-port writeback clears, busy queries and sticky underflow.
//  Revision: 1.0 - initial release
// ============================================================================
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter int ADDR_W         = c_addr_w,
    parameter int CNT_W          = c_cnt_w,
    parameter int CLR_PORTS      = 2,
    parameter int RD_PORTS       = 2,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          set_valid,
    input  logic [ADDR_W-1:0]             set_addr,
    output logic                          set_ready,
    input  logic [CLR_PORTS-1:0]          clr_valid,
    input  logic [CLR_PORTS*ADDR_W-1:0]   clr_addr,
    input  logic [RD_PORTS*ADDR_W-1:0]    rd_addr,
    output logic [RD_PORTS-1:0]           rd_busy,
    output logic [2**ADDR_W-1:0]          busy_vec,
    output logic                          err_underflow
);

    localparam int              c_num   = 2 ** ADDR_W;
    // Enough bits to count every clear port hitting one entry
    localparam int              c_cw    = $clog2(CLR_PORTS + 1);
    // Arithmetic width for cnt + set, compared against the clear count
    localparam int              c_sw    = CNT_W + c_cw + 1;
    localparam logic [CNT_W-1:0] c_sat  = CNT_W'(cnt_sat(CNT_W));

    logic [c_num-1:0][CNT_W-1:0] r_cnt;
    logic                        r_err;

    logic                        w_set_fire;
    logic [c_num-1:0]            w_set_oh;
    logic [c_num-1:0]            w_clr_oh [CLR_PORTS];
    logic [c_num-1:0][CNT_W-1:0] w_next;
    logic [c_num-1:0]            w_uf;

    // Back-pressure looks only at the registered count, never at same-cycle clears
    assign set_ready  = (r_cnt[set_addr] != c_sat);
    assign w_set_fire = set_valid & set_ready;

    onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_set_dec (
        .en     (w_set_fire),
        .addr   (set_addr),
        .onehot (w_set_oh)
    );

    generate
        for (genvar k = 0; k < CLR_PORTS; k++) begin : g_clr_dec
            onehot_decoder #(
                .ADDR_W (ADDR_W)
            ) u_clr_dec (
                .en     (clr_valid[k]),
                .addr   (clr_addr[k*ADDR_W +: ADDR_W]),
                .onehot (w_clr_oh[k])
            );
        end
    endgenerate

    generate
        for (genvar i = 0; i < c_num; i++) begin : g_entry
            // Entry 0 is pinned to idle when the zero register is hardwired
            localparam bit c_pinned = (ZERO_HARDWIRED != 0) && (i == 0);

            logic [c_cw-1:0] w_clr_num;
            logic [c_sw-1:0] w_up;
            logic            w_under;

            // Number of clear ports that target this entry
            always_comb begin
                w_clr_num = '0;
                for (int k = 0; k < CLR_PORTS; k++) begin
                    w_clr_num = w_clr_num + c_cw'(w_clr_oh[k][i]);
                end
            end

            // cnt + s - c, clamped at zero with an underflow flag
            always_comb begin
                w_up    = c_sw'(r_cnt[i]) + c_sw'(w_set_oh[i]);
                w_under = (w_up < c_sw'(w_clr_num));
            end

            assign w_next[i]   = (w_under || c_pinned) ? '0 : CNT_W'(w_up - c_sw'(w_clr_num));
            assign w_uf[i]     = w_under & ~c_pinned;
            assign busy_vec[i] = |r_cnt[i];
        end
    endgenerate

    generate
        for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
            assign rd_busy[j] = |r_cnt[rd_addr[j*ADDR_W +: ADDR_W]];
        end
    endgenerate

    // Counter state: flush zeroes everything and wins over sets and clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    // Sticky underflow; a flushed cycle discards its clears so cannot underflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (!flush && (|w_uf)) begin
            r_err <= 1'b1;
        end
    end

    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : tb_decode_scoreboard
//  Brief   : Directed and random stimulus for decode_scoreboard with a
//            reference model feeding an expected-result queue.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        set_valid;
    logic [4:0]  set_addr;
    logic        set_ready;
    logic [1:0]  clr_valid;
    logic [9:0]  clr_addr;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;
    logic        err_underflow;

    decode_scoreboard #(
        .ADDR_W         (5),
        .CNT_W          (2),
        .CLR_PORTS      (2),
        .RD_PORTS       (2),
        .ZERO_HARDWIRED (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .set_valid     (set_valid),
        .set_addr      (set_addr),
        .set_ready     (set_ready),
        .clr_valid     (clr_valid),
        .clr_addr      (clr_addr),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy),
        .busy_vec      (busy_vec),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bv;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   m_cnt [32];
    bit   m_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 0;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input string tag, input bit fl, input bit sv, input int sa,
                        input bit cv0, input int ca0, input bit cv1, input int ca1,
                        input int ra0, input int ra1);
        exp_t e;
        exp_t got;
        bit   rdy;
        int   nxt [32];
        int   s;
        int   c;
        int   t;
        flush     = fl;
        set_valid = sv;
        set_addr  = 5'(sa);
        clr_valid = {cv1, cv0};
        clr_addr  = {5'(ca1), 5'(ca0)};
        rd_addr   = {5'(ra1), 5'(ra0)};
        #3;
        rdy = (m_cnt[sa] != 3);
        chk({tag, ":ready"}, 32'(set_ready), 32'(rdy));
        chk({tag, ":rd_busy"}, 32'(rd_busy), 32'({m_cnt[ra1] != 0, m_cnt[ra0] != 0}));
        for (int i = 0; i < 32; i++) begin
            s = (sv && rdy && sa == i) ? 1 : 0;
            c = ((cv0 && ca0 == i) ? 1 : 0) + ((cv1 && ca1 == i) ? 1 : 0);
            if (i == 0) begin
                t = 0;
            end else if (fl) begin
                t = 0;
            end else begin
                t = m_cnt[i] + s - c;
                if (t < 0) begin
                    t = 0;
                    m_err = 1;
                end
            end
            nxt[i] = t;
        end
        e.bv = '0;
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = nxt[i];
            e.bv[i] = (nxt[i] != 0);
        end
        e.err = m_err;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk({tag, ":busy_vec"}, busy_vec, got.bv);
        chk({tag, ":err"}, 32'(err_underflow), 32'(got.err));
    endtask

    task automatic idle(input string tag, input int ra0, input int ra1);
        step(tag, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; set_valid = 1'b0; set_addr = '0;
        clr_valid = '0; clr_addr = '0; rd_addr = '0;
        model_clear();
        #1 reset = 1'b1;
        #2;
        chk("rst:busy_vec", busy_vec, 32'h0);
        chk("rst:err", 32'(err_underflow), 32'h0);
        chk("rst:ready", 32'(set_ready), 32'h1);
        chk("rst:rd_busy", 32'(rd_busy), 32'h0);
        // Set presented under reset must be discarded
        set_valid = 1'b1; set_addr = 5'd4; rd_addr = {5'd4, 5'd4};
        @(posedge clk);
        #1 reset = 1'b0;
        set_valid = 1'b0;
        chk("rst:discard", busy_vec, 32'h0);

        // Zero register: accepted, no effect, no underflow
        step("r0_set", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("r0_clr", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("r0_idle", 0, 0);

        // Set and clear of an idle entry cancel out
        step("r9_setclr", 0, 1, 9, 0, 0, 1, 9, 9, 0);
        idle("r9_idle", 9, 9);

        // Saturation of r5
        step("r5_set1", 0, 1, 5, 0, 0, 0, 0, 5, 0);
        step("r5_set2", 0, 1, 5, 0, 0, 0, 0, 5, 0);
        step("r5_set3", 0, 1, 5, 0, 0, 0, 0, 5, 0);
        step("r5_set4", 0, 1, 5, 0, 0, 0, 0, 5, 0);
        idle("r5_idle", 5, 0);

        // Flush together with a set; query r3 through the flush
        step("r3_set", 0, 1, 3, 0, 0, 0, 0, 3, 31);
        step("r31_set", 0, 1, 31, 0, 0, 0, 0, 3, 31);
        step("flush", 1, 1, 3, 0, 0, 0, 0, 3, 31);
        idle("post_flush", 3, 31);

        // Double clear of a count of one underflows
        step("r7_set", 0, 1, 7, 0, 0, 0, 0, 7, 0);
        step("r7_clr2", 0, 0, 0, 1, 7, 1, 7, 7, 0);
        idle("r7_idle", 7, 0);

        // Asynchronous reset mid-cycle with r12 busy
        step("r12_set", 0, 1, 12, 0, 0, 0, 0, 12, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst:busy_vec", busy_vec, 32'h0);
        chk("arst:err", 32'(err_underflow), 32'h0);
        chk("arst:rd_busy", 32'(rd_busy), 32'h0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("arst:after", busy_vec, 32'h0);

        // Random traffic on a few entries to provoke collisions
        for (int n = 0; n < 40; n++) begin
            step("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 5, register-number width; entry count N = 2**ADDR_W.
- CNT_W, 2, width of each entry's outstanding-write counter.
- CLR_PORTS, 2, number of writeback (clear) ports.
- RD_PORTS, 2, number of busy-query ports.
- ZERO_HARDWIRED, 1, when 1 entry 0 is never busy.
REQ-002 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high, named reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- flush  in  1  clear all entries.
- set_valid  in  1  issue of a write to set_addr.
- set_addr  in  ADDR_W  destination register number.
- set_ready  out  1  set accepted this cycle.
- clr_valid  in  CLR_PORTS  per-port writeback strobe.
- clr_addr  in  CLR_PORTS*ADDR_W  per-port writeback register; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_addr  in  RD_PORTS*ADDR_W  query register numbers.
- rd_busy  out  RD_PORTS  per-query busy bit.
- busy_vec  out  N  one bit per entry, set when the entry counter is non-zero.
- err_underflow  out  1  sticky; set by a clear to an idle entry.

Function
REQ-004 Each entry i SHALL hold an unsigned CNT_W-bit counter cnt[i] of writes issued but not yet written back.
REQ-005 Set and clear addresses SHALL be converted to N-bit one-hot vectors by the decoder sub-module; all per-entry update logic SHALL be driven from these vectors.
REQ-006 A set SHALL be accepted on a cycle where set_valid=1 and set_ready=1.
REQ-007 set_ready SHALL be combinational, equal to (cnt[set_addr] != 2**CNT_W-1), computed from the current state. Same-cycle clears SHALL NOT raise it.
REQ-008 On each clock edge, cnt[i] SHALL update as cnt[i] + s - c, where:
- s = 1 if an accepted set targets entry i, else 0.
- c = the number of clear ports with clr_valid=1 whose clr_addr equals i.
REQ-009 If the result of REQ-008 would go below zero, cnt[i] SHALL become 0 and err_underflow SHALL be set on the next edge.
REQ-010 A simultaneous set and a single clear to the same entry SHALL leave its counter unchanged, with no underflow, even when the counter is 0.
REQ-011 flush=1 SHALL zero every counter on the next edge, overriding all sets and clears in that cycle. flush SHALL NOT alter err_underflow. set_ready during flush follows REQ-007.
REQ-012 With ZERO_HARDWIRED=1, entry 0 SHALL stay 0:
- Sets to entry 0 are accepted (set_ready=1) but have no effect.
- Clears to entry 0 are ignored and never raise err_underflow.
- busy_vec[0] and any rd_busy querying 0 read 0.
REQ-013 rd_busy[j] SHALL be (cnt[rd_addr[j]] != 0), combinational from registered state. There SHALL be no bypass of same-cycle sets or clears, so query-to-update latency is 1 cycle.
REQ-014 busy_vec SHALL be derived combinationally from the counters only.
REQ-015 err_underflow SHALL stay set until reset.

Reset
REQ-016 Asserting reset SHALL immediately clear all counters and err_underflow. Outputs then read as follows:
- busy_vec=0 and rd_busy=0.
- set_ready=1.
REQ-017 Sets and clears presented while reset is asserted SHALL be discarded. The first update SHALL occur on the first clock edge after deassertion.

Structure
REQ-018 A shared package SHALL hold the default ADDR_W, the derived N, and the counter-saturation constant, for reuse by the issue and hazard logic.
REQ-019 One sub-module, onehot_decoder, parametrised on ADDR_W, SHALL generalise the fixed-size decoders. It SHALL be instantiated once for set_addr and CLR_PORTS times for the clear addresses.
REQ-020 Query ports SHALL use plain indexing, with no decoder.

Verification
REQ-021 Scenario: set r5 ×3 on consecutive cycles (CNT_W=2).
- Required: cnt=3, busy_vec[5]=1.
- Required: a 4th set sees set_ready=0 and is not applied.
REQ-022 Scenario: cnt[7]=1, then clr r7 on both ports in one cycle.
- Required: cnt[7]=0 and err_underflow=1 on the next cycle.
REQ-023 Scenario: cnt[9]=0, then set r9 and clr r9 in the same cycle.
- Required: cnt[9]=0, busy_vec[9]=0, err_underflow=0.
REQ-024 Scenario: set r0, then clr r0, with ZERO_HARDWIRED=1.
- Required: set_ready=1, busy_vec[0]=0, err_underflow=0 throughout.
REQ-025 Scenario: r3 and r31 busy, then flush=1 together with set r3.
- Required: busy_vec=0 next cycle.
- Required: rd_busy for query r3 is 1 during the flush cycle and 0 after it.
REQ-026 Scenario: reset pulsed mid-run, asynchronous to clk, with r12 busy.
- Required: busy_vec=0 and err_underflow=0 before the next clock edge.
